// File: rtl/dp_ram_rr_arbiter_if.sv
// Request, RAM-port and response bundle for dp_ram_rr_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/RAM environment side.
interface dp_ram_rr_arbiter_if #(
  parameter int P_DATA_W         = 640,
  parameter int P_LOG2_RAM_DEPTH = 9,
  parameter int P_NUM_REQ        = 4,
  parameter int P_ID_W           = 2
);
  logic [P_NUM_REQ-1:0]                  i_req_valid;
  logic [P_NUM_REQ-1:0]                  i_req_wr;
  logic [P_NUM_REQ*P_LOG2_RAM_DEPTH-1:0] i_req_addr;
  logic [P_NUM_REQ*P_DATA_W-1:0]         i_req_data;
  logic [P_NUM_REQ-1:0]                  o_req_ready;

  logic                        o_ram_a_wr;
  logic                        o_ram_b_wr;
  logic [P_LOG2_RAM_DEPTH-1:0] o_ram_a_addr;
  logic [P_LOG2_RAM_DEPTH-1:0] o_ram_b_addr;
  logic [P_DATA_W-1:0]         o_ram_a_data;
  logic [P_DATA_W-1:0]         o_ram_b_data;
  logic [P_DATA_W-1:0]         i_ram_a_data;
  logic [P_DATA_W-1:0]         i_ram_b_data;

  logic                o_rsp_a_valid;
  logic                o_rsp_b_valid;
  logic [P_ID_W-1:0]   o_rsp_a_id;
  logic [P_ID_W-1:0]   o_rsp_b_id;
  logic [P_DATA_W-1:0] o_rsp_a_data;
  logic [P_DATA_W-1:0] o_rsp_b_data;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_addr, i_req_data, i_ram_a_data, i_ram_b_data,
    output o_req_ready, o_ram_a_wr, o_ram_b_wr, o_ram_a_addr, o_ram_b_addr,
           o_ram_a_data, o_ram_b_data, o_rsp_a_valid, o_rsp_b_valid,
           o_rsp_a_id, o_rsp_b_id, o_rsp_a_data, o_rsp_b_data
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_addr, i_req_data, i_ram_a_data, i_ram_b_data,
    input  o_req_ready, o_ram_a_wr, o_ram_b_wr, o_ram_a_addr, o_ram_b_addr,
           o_ram_a_data, o_ram_b_data, o_rsp_a_valid, o_rsp_b_valid,
           o_rsp_a_id, o_rsp_b_id, o_rsp_a_data, o_rsp_b_data
  );
endinterface

// File: rtl/dp_ram_rr_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among P_NUM_REQ requesters: up to two
// grants per cycle (port A then port B), same-address write hazards held off, 1-cycle read responses.
module dp_ram_rr_arbiter #(
  parameter int P_DATA_W         = 640,
  parameter int P_LOG2_RAM_DEPTH = 9,
  parameter int P_NUM_REQ        = 4,
  parameter int P_ID_W           = 2
) (
  input logic                i_clk,
  input logic                i_rst,
  dp_ram_rr_arbiter_if.slave bus
);
  localparam int                   L_AW  = P_LOG2_RAM_DEPTH;
  localparam logic [P_ID_W:0]      L_NUM = (P_ID_W+1)'(P_NUM_REQ);
  localparam logic [P_NUM_REQ-1:0] L_ONE = P_NUM_REQ'(1);

  logic [L_AW-1:0]     req_addr_s [P_NUM_REQ];
  logic [P_DATA_W-1:0] req_data_s [P_NUM_REQ];

  logic [P_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              rsp_a_valid_q, rsp_a_valid_d, rsp_b_valid_q, rsp_b_valid_d;
  logic [P_ID_W-1:0] rsp_a_id_q, rsp_b_id_q;
  logic [L_AW-1:0]   ram_a_addr_q, ram_b_addr_q;

  logic              grant_a, grant_b;
  logic [P_ID_W-1:0] a_idx, b_idx;
  logic [P_ID_W:0]   scan_sum;
  logic [P_ID_W-1:0] scan_idx;
  logic              conflict, take_a, take_b;
  logic [P_ID_W-1:0] last_idx_s;
  logic [P_ID_W:0]   next_sum_s;
  logic [L_AW-1:0]   ram_a_addr_s, ram_b_addr_s;

  for (genvar k = 0; k < P_NUM_REQ; k++) begin : g_slice
    assign req_addr_s[k] = bus.i_req_addr[k*L_AW +: L_AW];
    assign req_data_s[k] = bus.i_req_data[k*P_DATA_W +: P_DATA_W];
  end

  // Scan from rr_ptr with explicit wrap; first valid takes A, next non-conflicting valid takes B.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_sum = '0;
    scan_idx = '0;
    conflict = 1'b0;
    take_a   = 1'b0;
    take_b   = 1'b0;
    for (int off = 0; off < P_NUM_REQ; off++) begin
      scan_sum = {1'b0, rr_ptr_q} + (P_ID_W+1)'(off);
      scan_sum = (scan_sum >= L_NUM) ? (scan_sum - L_NUM) : scan_sum;
      scan_idx = scan_sum[P_ID_W-1:0];
      conflict = (req_addr_s[scan_idx] == req_addr_s[a_idx]) &&
                 (bus.i_req_wr[scan_idx] || bus.i_req_wr[a_idx]);
      take_a   = !i_rst && bus.i_req_valid[scan_idx] && !grant_a;
      take_b   = !i_rst && bus.i_req_valid[scan_idx] && grant_a && !grant_b && !conflict;
      a_idx    = take_a ? scan_idx : a_idx;
      b_idx    = take_b ? scan_idx : b_idx;
      grant_a  = grant_a | take_a;
      grant_b  = grant_b | take_b;
    end
  end

  assign bus.o_req_ready = (grant_a ? (L_ONE << a_idx) : '0) | (grant_b ? (L_ONE << b_idx) : '0);

  // Idle ports hold their last granted address but never write.
  assign ram_a_addr_s     = grant_a ? req_addr_s[a_idx] : ram_a_addr_q;
  assign ram_b_addr_s     = grant_b ? req_addr_s[b_idx] : ram_b_addr_q;
  assign bus.o_ram_a_wr   = grant_a & bus.i_req_wr[a_idx];
  assign bus.o_ram_b_wr   = grant_b & bus.i_req_wr[b_idx];
  assign bus.o_ram_a_addr = i_rst ? '0 : ram_a_addr_s;
  assign bus.o_ram_b_addr = i_rst ? '0 : ram_b_addr_s;
  assign bus.o_ram_a_data = grant_a ? req_data_s[a_idx] : '0;
  assign bus.o_ram_b_data = grant_b ? req_data_s[b_idx] : '0;

  assign last_idx_s    = grant_b ? b_idx : a_idx;
  assign next_sum_s    = {1'b0, last_idx_s} + (P_ID_W+1)'(1);
  assign rr_ptr_d      = !grant_a ? rr_ptr_q :
                         ((next_sum_s >= L_NUM) ? '0 : next_sum_s[P_ID_W-1:0]);
  assign rsp_a_valid_d = grant_a & ~bus.i_req_wr[a_idx];
  assign rsp_b_valid_d = grant_b & ~bus.i_req_wr[b_idx];

  // Pointer, held addresses and response tags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q      <= '0;
      rsp_a_valid_q <= 1'b0;
      rsp_b_valid_q <= 1'b0;
      rsp_a_id_q    <= '0;
      rsp_b_id_q    <= '0;
      ram_a_addr_q  <= '0;
      ram_b_addr_q  <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      rsp_a_valid_q <= rsp_a_valid_d;
      rsp_b_valid_q <= rsp_b_valid_d;
      rsp_a_id_q    <= a_idx;
      rsp_b_id_q    <= b_idx;
      ram_a_addr_q  <= ram_a_addr_s;
      ram_b_addr_q  <= ram_b_addr_s;
    end
  end

  // A reset arriving while a response is due suppresses that response.
  assign bus.o_rsp_a_valid = rsp_a_valid_q & ~i_rst;
  assign bus.o_rsp_b_valid = rsp_b_valid_q & ~i_rst;
  assign bus.o_rsp_a_id    = rsp_a_id_q;
  assign bus.o_rsp_b_id    = rsp_b_id_q;
  assign bus.o_rsp_a_data  = bus.i_ram_a_data;
  assign bus.o_rsp_b_data  = bus.i_ram_b_data;
endmodule

// File: tb/tb_dp_ram_rr_arbiter.sv
// Directed bench for dp_ram_rr_arbiter with a behavioural dual-port RAM (registered read,
// write-through) whose contents start as an address-derived pattern.
module tb_dp_ram_rr_arbiter;
  localparam int P_DATA_W = 640;
  localparam int P_AW     = 9;
  localparam int P_N      = 4;
  localparam int P_ID_W   = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [P_DATA_W-1:0] d_aa;
  logic [P_DATA_W-1:0] d_5c;
  logic [P_DATA_W-1:0] mem [0:(1<<P_AW)-1];
  logic [P_DATA_W-1:0] ram_a_q, ram_b_q;

  dp_ram_rr_arbiter_if #(.P_DATA_W(P_DATA_W), .P_LOG2_RAM_DEPTH(P_AW),
                         .P_NUM_REQ(P_N), .P_ID_W(P_ID_W)) bus ();

  dp_ram_rr_arbiter #(.P_DATA_W(P_DATA_W), .P_LOG2_RAM_DEPTH(P_AW),
                      .P_NUM_REQ(P_N), .P_ID_W(P_ID_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [P_DATA_W-1:0] pat(input int a);
    pat = {20{32'hA5A5_0000 | 32'(a)}};
  endfunction

  assign bus.i_ram_a_data = ram_a_q;
  assign bus.i_ram_b_data = ram_b_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << P_AW); i++) mem[i] <= pat(i);
      ram_a_q <= '0;
      ram_b_q <= '0;
    end else begin
      if (bus.o_ram_a_wr) begin
        mem[bus.o_ram_a_addr] <= bus.o_ram_a_data;
        ram_a_q <= bus.o_ram_a_data;
      end else ram_a_q <= mem[bus.o_ram_a_addr];
      if (bus.o_ram_b_wr) begin
        mem[bus.o_ram_b_addr] <= bus.o_ram_b_data;
        ram_b_q <= bus.o_ram_b_data;
      end else ram_b_q <= mem[bus.o_ram_b_addr];
    end
  end

  task automatic set_req(input logic [P_ID_W-1:0] k, input logic v, input logic w,
                         input logic [P_AW-1:0] a, input logic [P_DATA_W-1:0] d);
    bus.i_req_valid[k] = v;
    bus.i_req_wr[k]    = w;
    bus.i_req_addr[k*P_AW +: P_AW]             = a;
    bus.i_req_data[k*P_DATA_W +: P_DATA_W]     = d;
  endtask

  task automatic clear_reqs();
    bus.i_req_valid = '0;
    bus.i_req_wr    = '0;
    bus.i_req_addr  = '0;
    bus.i_req_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    for (int k = 0; k < P_N; k++) set_req(P_ID_W'(k), 1'b1, 1'b0, P_AW'(32 + k), '0);
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b exp 0000", bus.o_req_ready); end
      n_cmp++; if (bus.o_ram_a_wr !== 1'b0 || bus.o_ram_b_wr !== 1'b0) begin n_fail++; $display("FAIL rst_ram_wr: got %b/%b exp 0/0", bus.o_ram_a_wr, bus.o_ram_b_wr); end
      n_cmp++; if (bus.o_ram_a_addr !== 9'h000) begin n_fail++; $display("FAIL rst_ram_a_addr: got %h exp 000", bus.o_ram_a_addr); end
      n_cmp++; if (bus.o_rsp_a_valid !== 1'b0 || bus.o_rsp_b_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b/%b exp 0/0", bus.o_rsp_a_valid, bus.o_rsp_b_valid); end
    end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (bus.o_req_ready !== 4'b0011) begin n_fail++; $display("FAIL rel_ready: got %b exp 0011", bus.o_req_ready); end
    n_cmp++; if (bus.o_ram_a_addr !== 9'h020 || bus.o_ram_b_addr !== 9'h021) begin n_fail++; $display("FAIL rel_addr: got %h/%h exp 020/021", bus.o_ram_a_addr, bus.o_ram_b_addr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_valid !== 1'b1 || bus.o_rsp_a_id !== 2'd0) begin n_fail++; $display("FAIL rel_rsp_a: got v%b id%0d exp v1 id0", bus.o_rsp_a_valid, bus.o_rsp_a_id); end
    n_cmp++; if (bus.o_rsp_b_valid !== 1'b1 || bus.o_rsp_b_id !== 2'd1) begin n_fail++; $display("FAIL rel_rsp_b: got v%b id%0d exp v1 id1", bus.o_rsp_b_valid, bus.o_rsp_b_id); end
    n_cmp++; if (bus.o_rsp_a_data !== pat(32)) begin n_fail++; $display("FAIL rel_rsp_a_data: got %h exp %h", bus.o_rsp_a_data, pat(32)); end
    n_cmp++; if (bus.o_req_ready !== 4'b1100) begin n_fail++; $display("FAIL rel_ptr2_ready: got %b exp 1100", bus.o_req_ready); end
  endtask

  task automatic test_round_robin();
    logic [3:0]      exp_rdy;
    logic [1:0]      exp_a;
    logic [P_AW-1:0] exp_addr;
    for (int i = 0; i < 4; i++) begin
      exp_rdy  = (i % 2 == 0) ? 4'b1100 : 4'b0011;
      exp_a    = (i % 2 == 0) ? 2'd2 : 2'd0;
      exp_addr = 9'h020 + {7'd0, exp_a};
      @(negedge clk); #1;
      n_cmp++; if (bus.o_req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b exp %b", i, bus.o_req_ready, exp_rdy); end
      n_cmp++; if (bus.o_ram_a_addr !== exp_addr || bus.o_ram_b_addr !== exp_addr + 9'd1) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h/%h exp %h/%h", i, bus.o_ram_a_addr, bus.o_ram_b_addr, exp_addr, exp_addr + 9'd1); end
      @(posedge clk); #1;
      n_cmp++; if (bus.o_rsp_a_valid !== 1'b1 || bus.o_rsp_a_id !== exp_a) begin n_fail++; $display("FAIL rr_rsp_a[%0d]: got v%b id%0d exp v1 id%0d", i, bus.o_rsp_a_valid, bus.o_rsp_a_id, exp_a); end
      n_cmp++; if (bus.o_rsp_b_valid !== 1'b1 || bus.o_rsp_b_id !== exp_a + 2'd1) begin n_fail++; $display("FAIL rr_rsp_b[%0d]: got v%b id%0d exp v1 id%0d", i, bus.o_rsp_b_valid, bus.o_rsp_b_id, exp_a + 2'd1); end
      n_cmp++; if (bus.o_rsp_b_data !== pat(33 + int'(exp_a))) begin n_fail++; $display("FAIL rr_rsp_b_data[%0d]: got %h exp %h", i, bus.o_rsp_b_data, pat(33 + int'(exp_a))); end
    end
  endtask

  task automatic test_idle_single();
    @(negedge clk); clear_reqs(); #1;
    n_cmp++; if (bus.o_req_ready !== 4'b0000 || bus.o_ram_a_wr !== 1'b0 || bus.o_ram_b_wr !== 1'b0) begin n_fail++; $display("FAIL idle_ready_wr: got %b %b%b exp 0000 00", bus.o_req_ready, bus.o_ram_a_wr, bus.o_ram_b_wr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_valid !== 1'b0 || bus.o_rsp_b_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_valid: got %b/%b exp 0/0", bus.o_rsp_a_valid, bus.o_rsp_b_valid); end
    @(negedge clk); set_req(2'd3, 1'b1, 1'b0, 9'h030, '0); #1;
    n_cmp++; if (bus.o_req_ready !== 4'b1000 || bus.o_ram_a_addr !== 9'h030 || bus.o_ram_b_wr !== 1'b0) begin n_fail++; $display("FAIL single_grant: got %b a%h bwr%b exp 1000 a030 bwr0", bus.o_req_ready, bus.o_ram_a_addr, bus.o_ram_b_wr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_valid !== 1'b1 || bus.o_rsp_a_id !== 2'd3 || bus.o_rsp_b_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp: got av%b id%0d bv%b exp av1 id3 bv0", bus.o_rsp_a_valid, bus.o_rsp_a_id, bus.o_rsp_b_valid); end
    n_cmp++; if (bus.o_rsp_a_data !== pat(48)) begin n_fail++; $display("FAIL single_rsp_data: got %h exp %h", bus.o_rsp_a_data, pat(48)); end
  endtask

  task automatic test_write_read_hazard();
    @(negedge clk); clear_reqs();
    set_req(2'd0, 1'b1, 1'b1, 9'h010, d_aa);
    set_req(2'd1, 1'b1, 1'b0, 9'h010, '0); #1;
    n_cmp++; if (bus.o_req_ready !== 4'b0001) begin n_fail++; $display("FAIL haz_ready: got %b exp 0001", bus.o_req_ready); end
    n_cmp++; if (bus.o_ram_a_wr !== 1'b1 || bus.o_ram_a_addr !== 9'h010 || bus.o_ram_b_wr !== 1'b0) begin n_fail++; $display("FAIL haz_port: got awr%b a%h bwr%b exp awr1 a010 bwr0", bus.o_ram_a_wr, bus.o_ram_a_addr, bus.o_ram_b_wr); end
    n_cmp++; if (bus.o_ram_a_data !== d_aa) begin n_fail++; $display("FAIL haz_wdata: got %h exp %h", bus.o_ram_a_data, d_aa); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_valid !== 1'b0 || bus.o_rsp_b_valid !== 1'b0) begin n_fail++; $display("FAIL haz_no_rsp: got %b/%b exp 0/0", bus.o_rsp_a_valid, bus.o_rsp_b_valid); end
    @(negedge clk); set_req(2'd0, 1'b0, 1'b0, 9'h000, '0); #1;
    n_cmp++; if (bus.o_req_ready !== 4'b0010 || bus.o_ram_a_addr !== 9'h010 || bus.o_ram_a_wr !== 1'b0) begin n_fail++; $display("FAIL haz_read_grant: got %b a%h awr%b exp 0010 a010 awr0", bus.o_req_ready, bus.o_ram_a_addr, bus.o_ram_a_wr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_valid !== 1'b1 || bus.o_rsp_a_id !== 2'd1) begin n_fail++; $display("FAIL haz_rsp: got v%b id%0d exp v1 id1", bus.o_rsp_a_valid, bus.o_rsp_a_id); end
    n_cmp++; if (bus.o_rsp_a_data !== d_aa) begin n_fail++; $display("FAIL haz_rsp_data: got %h exp %h", bus.o_rsp_a_data, d_aa); end
  endtask

  task automatic test_same_addr_reads();
    @(negedge clk); clear_reqs();
    set_req(2'd2, 1'b1, 1'b0, 9'h1FF, '0);
    set_req(2'd3, 1'b1, 1'b0, 9'h1FF, '0); #1;
    n_cmp++; if (bus.o_req_ready !== 4'b1100 || bus.o_ram_a_addr !== 9'h1FF || bus.o_ram_b_addr !== 9'h1FF) begin n_fail++; $display("FAIL same_grant: got %b %h/%h exp 1100 1ff/1ff", bus.o_req_ready, bus.o_ram_a_addr, bus.o_ram_b_addr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_id !== 2'd2 || bus.o_rsp_b_id !== 2'd3 || bus.o_rsp_a_valid !== 1'b1 || bus.o_rsp_b_valid !== 1'b1) begin n_fail++; $display("FAIL same_rsp: got v%b%b id%0d/%0d exp v11 id2/3", bus.o_rsp_a_valid, bus.o_rsp_b_valid, bus.o_rsp_a_id, bus.o_rsp_b_id); end
    n_cmp++; if (bus.o_rsp_a_data !== pat(511) || bus.o_rsp_b_data !== pat(511)) begin n_fail++; $display("FAIL same_rsp_data: got a=%h b=%h exp %h", bus.o_rsp_a_data[31:0], bus.o_rsp_b_data[31:0], pat(511)); end
  endtask

  task automatic test_skip_conflict();
    @(negedge clk); clear_reqs();
    set_req(2'd0, 1'b1, 1'b1, 9'd5, d_5c);
    set_req(2'd1, 1'b1, 1'b0, 9'd5, '0);
    set_req(2'd2, 1'b1, 1'b0, 9'd7, '0); #1;
    n_cmp++; if (bus.o_req_ready !== 4'b0101) begin n_fail++; $display("FAIL skip_ready: got %b exp 0101", bus.o_req_ready); end
    n_cmp++; if (bus.o_ram_a_wr !== 1'b1 || bus.o_ram_a_addr !== 9'd5 || bus.o_ram_b_wr !== 1'b0 || bus.o_ram_b_addr !== 9'd7) begin n_fail++; $display("FAIL skip_ports: got awr%b a%h bwr%b b%h exp awr1 a005 bwr0 b007", bus.o_ram_a_wr, bus.o_ram_a_addr, bus.o_ram_b_wr, bus.o_ram_b_addr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_valid !== 1'b0 || bus.o_rsp_b_valid !== 1'b1 || bus.o_rsp_b_id !== 2'd2) begin n_fail++; $display("FAIL skip_rsp: got av%b bv%b bid%0d exp av0 bv1 bid2", bus.o_rsp_a_valid, bus.o_rsp_b_valid, bus.o_rsp_b_id); end
    // All four valid now: from rr_ptr=3 the pair is (3,0).
    @(negedge clk);
    set_req(2'd0, 1'b1, 1'b0, 9'd11, '0);
    set_req(2'd3, 1'b1, 1'b0, 9'd9, '0); #1;
    n_cmp++; if (bus.o_req_ready !== 4'b1001 || bus.o_ram_a_addr !== 9'd9 || bus.o_ram_b_addr !== 9'd11) begin n_fail++; $display("FAIL skip_ptr3: got %b %h/%h exp 1001 009/00b", bus.o_req_ready, bus.o_ram_a_addr, bus.o_ram_b_addr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_id !== 2'd3 || bus.o_rsp_b_id !== 2'd0 || bus.o_rsp_a_data !== pat(9) || bus.o_rsp_b_data !== pat(11)) begin n_fail++; $display("FAIL skip_ptr3_rsp: got id%0d/%0d a=%h b=%h exp id3/0", bus.o_rsp_a_id, bus.o_rsp_b_id, bus.o_rsp_a_data[31:0], bus.o_rsp_b_data[31:0]); end
    @(negedge clk); #1;
    n_cmp++; if (bus.o_req_ready !== 4'b0110 || bus.o_ram_a_addr !== 9'd5) begin n_fail++; $display("FAIL skip_wait_grant: got %b a%h exp 0110 a005", bus.o_req_ready, bus.o_ram_a_addr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_id !== 2'd1 || bus.o_rsp_a_data !== d_5c) begin n_fail++; $display("FAIL skip_wait_rsp: got id%0d data=%h exp id1 data=%h", bus.o_rsp_a_id, bus.o_rsp_a_data, d_5c); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); clear_reqs();
    set_req(2'd3, 1'b1, 1'b0, 9'h040, '0); #1;
    n_cmp++; if (bus.o_req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_grant: got %b exp 1000", bus.o_req_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(2'd0, 1'b1, 1'b0, 9'h041, '0); #1;
    n_cmp++; if (bus.o_rsp_a_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_drop: got %b exp 0", bus.o_rsp_a_valid); end
    n_cmp++; if (bus.o_req_ready !== 4'b0000 || bus.o_ram_a_wr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b awr%b exp 0000 awr0", bus.o_req_ready, bus.o_ram_a_wr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_after: got %b exp 0", bus.o_rsp_a_valid); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (bus.o_req_ready !== 4'b1001 || bus.o_ram_a_addr !== 9'h041 || bus.o_ram_b_addr !== 9'h040) begin n_fail++; $display("FAIL mid_ptr0: got %b %h/%h exp 1001 041/040", bus.o_req_ready, bus.o_ram_a_addr, bus.o_ram_b_addr); end
    @(posedge clk); #1;
    n_cmp++; if (bus.o_rsp_a_id !== 2'd0 || bus.o_rsp_b_id !== 2'd3 || bus.o_rsp_a_data !== pat(65) || bus.o_rsp_b_data !== pat(64)) begin n_fail++; $display("FAIL mid_post_rsp: got id%0d/%0d a=%h b=%h exp id0/3", bus.o_rsp_a_id, bus.o_rsp_b_id, bus.o_rsp_a_data[31:0], bus.o_rsp_b_data[31:0]); end
  endtask

  initial begin
    d_aa = {80{8'hAA}};
    d_5c = {80{8'h5C}};
    rst  = 1'b1;
    clear_reqs();
    test_reset();
    test_round_robin();
    test_idle_single();
    test_write_read_hazard();
    test_same_addr_reads();
    test_skip_conflict();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
